fpadd_issue_ctrl: RTL and testbench

Upstream issue/collect stage for the 3-cycle pipelined FP32 adder, which has no enable or valid of its own. It accepts operand pairs over valid/ready and drives the adder's reg_A/reg_B inputs. A tagged valid token is carried alongside each operation so the matching adder output is captured into a result FIFO. A credit scheme guarantees no result is ever dropped, even under output backpressure.

---
 rtl/fpadd_pkg.sv | 23 ++
 rtl/fpadd_result_fifo.sv | 68 ++++++
 rtl/fpadd_issue_ctrl.sv | 123 ++++++++++++
 tb/tb_fpadd_issue_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpadd_pkg.sv
// Shared FP32 field definitions and constants for the FP adder issue/collect slice.
package fpadd_pkg;

    localparam int FP32_W = 32;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;
    localparam int MAN_LSB  = 0;

    localparam int FPADD_LATENCY = 3;

    localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;

    // True when the exponent field is all zeros (zero or subnormal operand).
    function automatic logic expIsZero(input logic [FP32_W-1:0] x);
        return (x[EXP_MSB:EXP_LSB] == '0);
    endfunction

endpackage

// File: rtl/fpadd_result_fifo.sv
// First-word-fall-through result FIFO with async active-high reset.
// The head output holds the last popped entry while the FIFO is empty.
module fpadd_result_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 36
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [W-1:0]           pushData_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output logic [W-1:0]           data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic [W-1:0]  hold_q;
    logic          popEff;

    assign valid_o = (count_q != '0);
    assign popEff  = pop_i & valid_o;
    assign count_o = count_q;
    assign data_o  = valid_o ? mem[rdPtr_q] : hold_q;

    // Occupancy update: simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        case ({push_i, popEff})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array is not reset; entries are only visible once written.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem[wrPtr_q] <= pushData_i;
        end
    end

    // Pointers, count and the held head value for the empty case.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_i) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (popEff) begin
                rdPtr_q <= rdPtr_q + AW'(1);
                hold_q  <= mem[rdPtr_q];
            end
        end
    end

endmodule

// File: rtl/fpadd_issue_ctrl.sv
// Issue/collect controller for the 3-cycle pipelined FP32 adder.
// Tokens travel alongside each operation so its result is captured into a
// result FIFO; credits (FIFO count plus in-flight ops) keep the FIFO from
// ever overflowing. Optional macro FPADD_IN_FTZ_EN flushes operands with a
// zero exponent field to +0 before they reach the adder.
module fpadd_issue_ctrl
    import fpadd_pkg::*;
#(
    parameter int LATENCY    = FPADD_LATENCY,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP32_W-1:0] in_a,
    input  logic [FP32_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [FP32_W-1:0] add_a,
    output logic [FP32_W-1:0] add_b,
    input  logic [FP32_W-1:0] add_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP32_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + LATENCY + 2) + 1;

    logic [LATENCY:0]            vsr_q;
    logic [TAG_W-1:0]            tagPipe_q [LATENCY+1];
    logic [FP32_W-1:0]           addA_q, addA_d;
    logic [FP32_W-1:0]           addB_q, addB_d;
    logic                        fire;
    logic                        push;
    logic                        pop;
    logic                        fifoValid;
    logic [FCW-1:0]              fifoCount;
    logic [CNT_W-1:0]            inflight;
    logic [CNT_W-1:0]            used;
    logic [FP32_W+TAG_W-1:0]     fifoHead;

    assign fire      = in_valid & in_ready;
    assign push      = vsr_q[LATENCY];
    assign pop       = fifoValid & out_ready;
    assign add_a     = addA_q;
    assign add_b     = addB_q;
    assign out_valid = fifoValid;
    assign out_data  = fifoHead[FP32_W+TAG_W-1:TAG_W];
    assign out_tag   = fifoHead[TAG_W-1:0];
    assign busy      = (inflight != '0) | (fifoCount != '0);

    // Credit check from registered state only: every token still in the pipe
    // (including one about to be pushed) reserves a FIFO slot.
    always_comb begin
        inflight = '0;
        for (int k = 0; k <= LATENCY; k++) begin
            inflight = inflight + CNT_W'(vsr_q[k]);
        end
        used     = CNT_W'(fifoCount) + inflight;
        in_ready = !reset && (used < CNT_W'(FIFO_DEPTH));
    end

    // Operand select: accepted pair goes to the adder, idle cycles feed zeros.
    always_comb begin
        addA_d = FP32_ZERO;
        addB_d = FP32_ZERO;
        if (fire) begin
`ifdef FPADD_IN_FTZ_EN
            addA_d = expIsZero(in_a) ? FP32_ZERO : in_a;
            addB_d = expIsZero(in_b) ? FP32_ZERO : in_b;
`else
            addA_d = in_a;
            addB_d = in_b;
`endif
        end
    end

    // Adder operand registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addA_q <= '0;
            addB_q <= '0;
        end else begin
            addA_q <= addA_d;
            addB_q <= addB_d;
        end
    end

    // Valid token pipe and its parallel tag pipe, advancing every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsr_q <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                tagPipe_q[k] <= '0;
            end
        end else begin
            vsr_q        <= {vsr_q[LATENCY-1:0], fire};
            tagPipe_q[0] <= fire ? in_tag : '0;
            for (int k = 1; k <= LATENCY; k++) begin
                tagPipe_q[k] <= tagPipe_q[k-1];
            end
        end
    end

    fpadd_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FP32_W + TAG_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .pushData_i ({add_result, tagPipe_q[LATENCY]}),
        .pop_i      (pop),
        .valid_o    (fifoValid),
        .data_o     (fifoHead),
        .count_o    (fifoCount)
    );

endmodule

// File: tb/tb_fpadd_issue_ctrl.sv
// Bench for fpadd_issue_ctrl with a behavioural 3-cycle FP32 adder and an
// outstanding-operation scoreboard.
module tb_fpadd_issue_ctrl;

    localparam int LAT   = 3;
    localparam int DEPTH = 8;
    localparam int TW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          inValid;
    logic          inReady;
    logic [31:0]   inA, inB;
    logic [TW-1:0] inTag;
    logic [31:0]   addA, addB, addResult;
    logic          outValid;
    logic          outReady;
    logic [31:0]   outData;
    logic [TW-1:0] outTag;
    logic          busy;

    always #5 clk = ~clk;

    fpadd_issue_ctrl #(
        .LATENCY    (LAT),
        .FIFO_DEPTH (DEPTH),
        .TAG_W      (TW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_a       (inA),
        .in_b       (inB),
        .in_tag     (inTag),
        .add_a      (addA),
        .add_b      (addB),
        .add_result (addResult),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_data   (outData),
        .out_tag    (outTag),
        .busy       (busy)
    );

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real f2r(input logic [31:0] x);
        real v;
        int  e = int'(x[30:23]);
        if (e == 0) v = real'(x[22:0]) * pow2(-149);
        else        v = (1.0 + real'(x[22:0]) / 8388608.0) * pow2(e - 127);
        return x[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        logic [63:0] d;
        int          ee;
        if (v == 0.0) return 32'h0;
        d  = $realtobits(v);
        ee = int'(d[62:52]) - 1023 + 127;
        if (ee <= 0) return {d[63], 31'h0};
        return {d[63], ee[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] i2f(input int k);
        return r2f(real'(k));
    endfunction

    function automatic logic [31:0] fpAdd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] ftzRef(input logic [31:0] x);
`ifdef FPADD_IN_FTZ_EN
        if (x[30:23] == 8'h00) return 32'h0;
`endif
        return x;
    endfunction

    // Behavioural pipelined adder: three edges from reg_A/reg_B to out.
    logic [31:0] p1, p2;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            p1 <= '0; p2 <= '0; addResult <= '0;
        end else begin
            p1 <= fpAdd(addA, addB);
            p2 <= p1;
            addResult <= p2;
        end
    end

    typedef struct {
        logic [31:0]   data;
        logic [TW-1:0] tag;
        int            readyEdge;
    } pend_t;

    typedef struct {
        logic [31:0]   a;
        logic [31:0]   b;
        logic [TW-1:0] tag;
        logic [31:0]   expData;
    } vec_t;

    pend_t         sb[$];
    int            edgeNo;
    logic [31:0]   lastData;
    logic [TW-1:0] lastTag;
    logic [31:0]   expA, expB;
    int            vectors;
    int            miscompares;
    logic          sOutValid, sBusy;
    logic [31:0]   sOutData, sAddA;
    logic [TW-1:0] sOutTag;
    logic          lastFire, lastPop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edgeNo);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input logic [TW-1:0] t);
        inValid = v; inA = a; inB = b; inTag = t;
    endtask

    // Compare every observable output against the outstanding-op model.
    task automatic checkOutput();
        logic expValid;
        expValid  = (sb.size() > 0) && (sb[0].readyEdge <= edgeNo);
        sOutValid = outValid; sOutData = outData; sOutTag = outTag;
        sBusy = busy; sAddA = addA;
        check("in_ready", {31'b0, inReady}, {31'b0, (!reset && sb.size() < DEPTH)});
        check("out_valid", {31'b0, outValid}, {31'b0, expValid});
        check("out_data", outData, expValid ? sb[0].data : lastData);
        check("out_tag", {28'b0, outTag}, {28'b0, expValid ? sb[0].tag : lastTag});
        check("busy", {31'b0, busy}, {31'b0, sb.size() > 0});
        check("add_a", addA, expA);
        check("add_b", addB, expB);
        check("push_into_full", {31'b0, dut.push && (dut.fifoCount == DEPTH) && !dut.pop}, 32'h0);
    endtask

    task automatic step();
        @(negedge clk);
        checkOutput();
        lastFire = inValid && inReady;
        lastPop  = outValid && outReady;
        @(posedge clk);
        edgeNo++;
        if (reset) begin
            sb.delete(); expA = 0; expB = 0;
        end else begin
            if (lastPop && sb.size() > 0) begin
                lastData = sb[0].data; lastTag = sb[0].tag;
                void'(sb.pop_front());
            end
            if (lastFire) begin
                sb.push_back('{fpAdd(ftzRef(inA), ftzRef(inB)), inTag, edgeNo + LAT + 1});
                expA = ftzRef(inA); expB = ftzRef(inB);
            end else begin
                expA = 0; expB = 0;
            end
        end
        #1;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        sb.delete(); lastData = 0; lastTag = 0; expA = 0; expB = 0;
        applyStimulus(0, 0, 0, 0);
        step(); step();
        reset = 1'b0;
    endtask

    // Issue one op, wait (bounded) for its result and return latency and head.
    task automatic singleOp(input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t,
                            output int lat, output logic [31:0] d, output logic [TW-1:0] tg);
        lat = 0; d = 'x; tg = 'x;
        applyStimulus(1, a, b, t);
        step();
        applyStimulus(0, 0, 0, 0);
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            step();
            if (sOutValid) begin lat = c; d = sOutData; tg = sOutTag; end
        end
    endtask

    vec_t          tbl[5];
    int            lat, nFire, nPop;
    logic [31:0]   d;
    logic [TW-1:0] tg;

    initial begin
        vectors = 0; miscompares = 0; edgeNo = 0;
        lastData = 0; lastTag = 0; expA = 0; expB = 0;
        outReady = 1'b1;
        applyStimulus(0, 0, 0, 0);

        tbl[0] = '{32'h3F80_0000, 32'h4000_0000, 4'd5, 32'h4040_0000};
        tbl[1] = '{32'h40A0_0000, 32'hC0A0_0000, 4'd3, 32'h0000_0000};
        tbl[2] = '{32'h4120_0000, 32'h3F80_0000, 4'd7, 32'h4130_0000};
        tbl[3] = '{32'h4040_0000, 32'h4080_0000, 4'd12, 32'h40E0_0000};
        tbl[4] = '{32'h0000_0001, 32'h3F80_0000, 4'd9, 32'h3F80_0000};

        applyReset();

        // Table-driven single ops: latency, result, tag, busy after pop.
        for (int i = 0; i < 5; i++) begin
            singleOp(tbl[i].a, tbl[i].b, tbl[i].tag, lat, d, tg);
            check($sformatf("tbl%0d_latency", i), lat, 5);
            check($sformatf("tbl%0d_data", i), d, tbl[i].expData);
            check($sformatf("tbl%0d_tag", i), {28'b0, tg}, {28'b0, tbl[i].tag});
            step();
            check($sformatf("tbl%0d_busy_after_pop", i), {31'b0, sBusy}, 32'h0);
        end

        // Operand flush: add_a seen by the adder one cycle after acceptance.
        applyStimulus(1, 32'h0000_0001, 32'h3F80_0000, 4'd1);
        step();
        applyStimulus(0, 0, 0, 0);
        step();
`ifdef FPADD_IN_FTZ_EN
        check("ftz_add_a", sAddA, 32'h0000_0000);
`else
        check("ftz_add_a", sAddA, 32'h0000_0001);
`endif
        repeat (8) step();

        // Back-to-back stream of 16 with the consumer always ready.
        nFire = 0; nPop = 0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1, i2f(k), 32'h3F80_0000, TW'(k));
            step();
            if (lastFire) nFire++;
            if (lastPop) nPop++;
        end
        applyStimulus(0, 0, 0, 0);
        for (int c = 0; c < 12; c++) begin
            step();
            if (lastPop) nPop++;
        end
        check("stream_accepts", nFire, 16);
        check("stream_pops", nPop, 16);

        // Backpressure: exactly DEPTH accepted, then drain all of them.
        outReady = 1'b0; nFire = 0; nPop = 0;
        for (int k = 0; k < 14; k++) begin
            applyStimulus(1, i2f(100 + k), i2f(k), TW'(k));
            step();
            if (lastFire) nFire++;
        end
        applyStimulus(0, 0, 0, 0);
        check("bp_accepts", nFire, DEPTH);
        outReady = 1'b1;
        for (int c = 0; c < 14; c++) begin
            step();
            if (lastPop) nPop++;
        end
        check("bp_drained", nPop, DEPTH);

        // Reset with three ops in flight and two in the FIFO.
        outReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, i2f(k + 1), i2f(k + 1), TW'(k));
            step();
        end
        applyStimulus(0, 0, 0, 0);
        step();
        applyReset();
        step();
        check("rst_out_valid", {31'b0, sOutValid}, 32'h0);
        check("rst_busy", {31'b0, sBusy}, 32'h0);
        outReady = 1'b1;
        repeat (8) step();
        singleOp(32'h4040_0000, 32'h4080_0000, 4'hA, lat, d, tg);
        check("post_rst_latency", lat, 5);
        check("post_rst_data", d, 32'h40E0_0000);
        check("post_rst_tag", {28'b0, tg}, 32'hA);

        // Randomised traffic with random consumer backpressure.
        for (int c = 0; c < 400; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), i2f(int'($urandom_range(0, 400)) - 200),
                          i2f(int'($urandom_range(0, 400)) - 200), TW'($urandom_range(0, 15)));
            outReady = ($urandom_range(0, 3) != 0);
            step();
        end
        applyStimulus(0, 0, 0, 0);
        outReady = 1'b1;
        repeat (16) step();
        check("final_idle", {31'b0, sBusy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
